// File: rtl/serial_add16.sv
// serial_add16 -- bit-serial adder built from one my_FA full adder and a carry flip-flop.
// Operands are captured on an accepted start and added LSB-first, one bit per clock.
// sum/cout are registered and only change when an operation completes; done pulses
// for exactly one cycle per completed operation.
// Optional build macro: SERIAL_ADD16_SUBTRACT_EN adds a 'sub' port. When sub=1 on accept,
// ~b and a carry-in of 1 are loaded, so {cout,sum} = a - b (cout=1 means no borrow).

// Single-bit full adder used as the arithmetic core of the serial adder.
module my_FA (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic R,
    output logic Cout
);
    // Sum and carry of three single-bit inputs.
    assign R    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_add16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD16_SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_r;
    logic             fa_cout;
    logic             sub_sel;

`ifdef SERIAL_ADD16_SUBTRACT_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    // The one full adder: always looks at the current LSBs and the carry flip-flop.
    my_FA u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (carry_q),
        .R    (fa_r),
        .Cout (fa_cout)
    );

    // Next-state logic: operand load on accept, one bit per cycle in RUN, result commit on last bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    a_sh_d   = a;
                    b_sh_d   = sub_sel ? ~b : b;
                    carry_d  = sub_sel ? 1'b1 : cin;
                    res_sh_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {fa_r, res_sh_q[WIDTH-1:1]};
                carry_d  = fa_cout;
                if (cnt_q == CNT_LAST) begin
                    // Last bit: the freshly shifted result word is the final sum.
                    state_d = S_DONE;
                    sum_d   = {fa_r, res_sh_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset also clears any visible result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_add16.sv
// Directed and randomized bench for serial_add16; expected results come from plain
// integer arithmetic on the operands, not from the adder's internal structure.
module tb_serial_add16;
    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int errors = 0;
    int checks = 0;
    int ops_done = 0;
    int done_seen = 0;

    serial_add16 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD16_SUBTRACT_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Independent tally of done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one operation starting from an IDLE/DONE cycle; leaves the bench in the DONE cycle.
    task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input logic op_cin, input logic op_sub,
                         input int inject_at, input string tag);
        logic [W:0] exp;
        int cycles;
        int busy_cnt;
        if (op_sub) exp = {1'b0, op_a} + {1'b0, ~op_b} + (W+1)'(1);
        else        exp = {1'b0, op_a} + {1'b0, op_b} + (W+1)'(op_cin);
        a = op_a; b = op_b; cin = op_cin; sub = op_sub; start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && cycles < W + 5) begin
            if (busy === 1'b1) busy_cnt++;
            if (cycles == inject_at) begin
                start = 1'b1; a = ~op_a; b = op_a; cin = ~op_cin;
            end else begin
                start = 1'b0;
            end
            tick();
            cycles++;
        end
        start = 1'b0;
        check({tag, "_latency"}, cycles, W);
        check({tag, "_busycnt"}, busy_cnt, W);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 0);
        check({tag, "_sum"}, {16'd0, sum}, {16'd0, exp[W-1:0]});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp[W]});
        ops_done++;
        $display("op %s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d (exp %h/%0d)",
                 tag, op_a, op_b, op_cin, op_sub, sum, cout, exp[W-1:0], exp[W]);
    endtask

    // Drop start for one cycle after a DONE cycle and confirm the pulse ended.
    task automatic go_idle(input string tag);
        start = 1'b0;
        tick();
        check({tag, "_done_pulse_end"}, {31'd0, done}, 0);
        check({tag, "_idle_busy"}, {31'd0, busy}, 0);
    endtask

    initial begin
        int dn;
        int gap;
        logic [W-1:0] ra, rb;
        logic rc;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick();
        tick();
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_sum", {16'd0, sum}, 0);
        check("reset_cout", {31'd0, cout}, 0);
        rst = 1'b0;
        tick();

        // 1: simple add
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, -1, "t1");
        check("t1_sum_const", {16'd0, sum}, 32'h0002);
        go_idle("t1");

        // 2: overflow, then back-to-back start held in DONE
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, -1, "t2a");
        check("t2a_sum_const", {15'd0, cout, sum}, 32'h10000);
        do_op(16'h1234, 16'h4321, 1'b1, 1'b0, -1, "t2b");
        check("t2b_sum_const", {15'd0, cout, sum}, 32'h05556);
        go_idle("t2b");

        // 3: start during RUN is ignored
        do_op(16'h8000, 16'h8000, 1'b1, 1'b0, 4, "t3");
        check("t3_sum_const", {15'd0, cout, sum}, 32'h10001);
        go_idle("t3");

        // 4: reset mid-run aborts without a done pulse
        a = 16'h00FF; b = 16'h0F0F; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_busy", {31'd0, busy}, 0);
        check("t4_done", {31'd0, done}, 0);
        check("t4_sum", {16'd0, sum}, 0);
        check("t4_cout", {31'd0, cout}, 0);
        dn = 0;
        for (int i = 0; i < W + 3; i++) begin
            if (done === 1'b1) dn++;
            tick();
        end
        check("t4_no_done", dn, 0);
        do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, -1, "t4post");
        go_idle("t4post");

`ifdef SERIAL_ADD16_SUBTRACT_EN
        // 5: subtract mode
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, -1, "t5a");
        check("t5a_const", {15'd0, cout, sum}, 32'h0FFFE);
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, -1, "t5b");
        check("t5b_const", {15'd0, cout, sum}, 32'h10002);
        go_idle("t5b");
`endif

        // 6: random operations with random gaps (including back-to-back)
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            do_op(ra, rb, rc, 1'b0, -1, "rnd");
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                go_idle("rnd");
                for (int g = 1; g < gap; g++) tick();
            end
        end
        go_idle("final");

        check("done_count", done_seen, ops_done);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
